// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding, frame bit positions and idle levels for spi_master
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CS_SETUP = 2'd1,
    ST_SHIFT    = 2'd2,
    ST_CS_HOLD  = 2'd3
  } spi_state_e;

  localparam logic [3:0] START_P      = 4'd0;
  localparam logic [3:0] DATA_P_FIRST = 4'd1;
  localparam logic [3:0] DATA_P_LAST  = 4'd8;
  localparam logic [3:0] STOP_P       = 4'd9;
  localparam logic [3:0] HUNT_MAX     = 4'd3;
  localparam logic [3:0] RX_BITS      = 4'd8;

  localparam logic SCLK_IDLE = 1'b0;
  localparam logic MOSI_IDLE = 1'b1;
  localparam logic CS_IDLE   = 1'b1;

  // Level driven on mosi for period p: start bit, data MSB first, then stop level.
  function automatic logic frame_bit(input logic [3:0] p, input logic [7:0] data);
    logic [2:0] idx;
    idx = 3'(DATA_P_LAST - p);
    if (p == START_P)
      frame_bit = 1'b0;
    else if (p >= DATA_P_FIRST && p < STOP_P)
      frame_bit = data[idx];
    else
      frame_bit = MOSI_IDLE;
  endfunction

endpackage

// File: rtl/spi_if.sv
// rtl/spi_if.sv - request/response and serial pins of spi_master
interface spi_if;
  logic       start;
  logic [7:0] tx_data;
  logic       busy;
  logic       done;
  logic [7:0] rx_data;
  logic       rx_err;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic       cs;

  modport master (
    input  start, tx_data, miso,
    output busy, done, rx_data, rx_err, sclk, mosi, cs
  );

  modport slave (
    output start, tx_data, miso,
    input  busy, done, rx_data, rx_err, sclk, mosi, cs
  );
endinterface

// File: rtl/spi_clk_gen.sv
// rtl/spi_clk_gen.sv - half-period divider producing tick/rise/fall strobes on clock_in
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clock_in,
  input  logic rs,
  input  logic en,
  input  logic shift,
  output logic tick,
  output logic rise,
  output logic fall
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] div_q, div_d;
  logic       phase_q, phase_d;

  always_ff @(posedge clock_in or negedge rs) begin
    if (!rs) begin
      div_q   <= 8'd0;
      phase_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      phase_q <= phase_d;
    end
  end

  // phase_q mirrors the sclk level so the strobe can be labelled rise or fall.
  always_comb begin
    tick    = en && (div_q == DIV_LAST);
    rise    = tick && shift && !phase_q;
    fall    = tick && shift && phase_q;
    div_d   = (!en || tick) ? 8'd0 : div_q + 8'd1;
    phase_d = !shift ? 1'b0 : (tick ? ~phase_q : phase_q);
  end

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - framed SPI master: start bit, 8 data bits, stop level; hunted start bit on miso
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int FRAME_LEN = 13
) (
  input logic   clock_in,
  input logic   rs,
  spi_if.master bus
);

  localparam logic [3:0] P_LAST = 4'(FRAME_LEN - 1);

  spi_state_e state_q, state_d;
  logic [3:0] p_q, p_d;
  logic [7:0] tx_q, tx_d;
  logic       start_seen_q, start_seen_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_err_q, rx_err_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       cs_q, cs_d;
  logic       sclk_q, sclk_d;
  logic       mosi_q, mosi_d;

  logic tick, rise, fall;
  logic accept, last_p, frame_end, rx_good;

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clock_in (clock_in),
    .rs       (rs),
    .en       (state_q != ST_IDLE),
    .shift    (state_q == ST_SHIFT),
    .tick     (tick),
    .rise     (rise),
    .fall     (fall)
  );

  // busy_q stays high through the done cycle, which blocks a start there.
  assign accept    = (state_q == ST_IDLE) && !busy_q && bus.start;
  assign last_p    = (p_q == P_LAST);
  assign frame_end = (state_q == ST_CS_HOLD) && tick;
  assign rx_good   = start_seen_q && (bit_cnt_q == RX_BITS);

  always_ff @(posedge clock_in or negedge rs) begin
    if (!rs) begin
      state_q      <= ST_IDLE;
      p_q          <= 4'd0;
      tx_q         <= 8'd0;
      start_seen_q <= 1'b0;
      bit_cnt_q    <= 4'd0;
      shreg_q      <= 8'd0;
      rx_data_q    <= 8'd0;
      rx_err_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cs_q         <= CS_IDLE;
      sclk_q       <= SCLK_IDLE;
      mosi_q       <= MOSI_IDLE;
    end else begin
      state_q      <= state_d;
      p_q          <= p_d;
      tx_q         <= tx_d;
      start_seen_q <= start_seen_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      rx_data_q    <= rx_data_d;
      rx_err_q     <= rx_err_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cs_q         <= cs_d;
      sclk_q       <= sclk_d;
      mosi_q       <= mosi_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (accept)          state_d = ST_CS_SETUP;
      ST_CS_SETUP: if (tick)            state_d = ST_SHIFT;
      ST_SHIFT:    if (fall && last_p)  state_d = ST_CS_HOLD;
      ST_CS_HOLD:  if (tick)            state_d = ST_IDLE;
      default:                          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_d         = tx_q;
    p_d          = p_q;
    start_seen_d = start_seen_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    rx_data_d    = rx_data_q;
    rx_err_d     = rx_err_q;
    busy_d       = accept || (state_q != ST_IDLE);
    done_d       = frame_end;
    cs_d         = (state_d == ST_IDLE) ? CS_IDLE : ~CS_IDLE;

    if (rise)
      sclk_d = 1'b1;
    else if (fall || state_q != ST_SHIFT)
      sclk_d = SCLK_IDLE;
    else
      sclk_d = sclk_q;

    if (rise)
      mosi_d = frame_bit(p_q, tx_q);
    else if (state_q != ST_SHIFT)
      mosi_d = MOSI_IDLE;
    else
      mosi_d = mosi_q;

    if (accept) begin
      tx_d         = bus.tx_data;
      p_d          = 4'd0;
      start_seen_d = 1'b0;
      bit_cnt_d    = 4'd0;
      shreg_d      = 8'd0;
    end

    // Receive hunt: first low miso within the hunt window, then eight data bits.
    if (fall) begin
      p_d = last_p ? 4'd0 : p_q + 4'd1;
      if (!start_seen_q) begin
        if (p_q <= HUNT_MAX && !bus.miso)
          start_seen_d = 1'b1;
      end else if (bit_cnt_q < RX_BITS) begin
        shreg_d   = {shreg_q[6:0], bus.miso};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end

    if (frame_end) begin
      rx_err_d = !rx_good;
      if (rx_good)
        rx_data_d = shreg_q;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_data_q;
  assign bus.rx_err  = rx_err_q;
  assign bus.sclk    = sclk_q;
  assign bus.mosi    = mosi_q;
  assign bus.cs      = cs_q;

endmodule
